// File: rtl/apu_pkg.sv
// Types and defaults shared between the loop sequencer and the apu.
// Holds the sweep FSM state encoding and the loop-index type.
package apu_pkg;

   localparam int BITS_DEF         = 8;
   localparam int LOG_LOOP_CNT_DEF = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   typedef logic [LOG_LOOP_CNT_DEF-1:0] loop_idx_t;

endpackage

// File: rtl/loop_sequencer_if.sv
// Configuration, control and iteration-stream signals of the loop sequencer.
// The master modport drives configuration and control; the slave is the sequencer.
interface loop_sequencer_if
   import apu_pkg::*;
#(
   parameter int BITS         = BITS_DEF,
   parameter int LOG_LOOP_CNT = LOG_LOOP_CNT_DEF
);
   localparam int LOOP_CNT = 1 << LOG_LOOP_CNT;

   logic                       cfg_we;
   logic [LOG_LOOP_CNT-1:0]    cfg_idx;
   logic [BITS-1:0]            cfg_bound;
   logic                       start;
   logic                       stall;
   logic                       busy;
   logic                       done;
   logic                       iter_valid;
   logic [LOOP_CNT*BITS-1:0]   iter_idx;
   logic [BITS-1:0]            di;
   logic [LOG_LOOP_CNT-1:0]    loop_var;
   logic                       change_loop_var;

   modport master (
      output cfg_we, cfg_idx, cfg_bound, start, stall,
      input  busy, done, iter_valid, iter_idx, di, loop_var, change_loop_var
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_bound, start, stall,
      output busy, done, iter_valid, iter_idx, di, loop_var, change_loop_var
   );

endinterface

// File: rtl/loop_level.sv
// One nested-loop counter: increments when enabled, wraps at bound-1.
// at_max_o lets the parent form the carry into the next level.
module loop_level #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear_i,
   input  logic            en_i,
   input  logic [BITS-1:0] bound_i,
   output logic [BITS-1:0] cnt_o,
   output logic            at_max_o
);

   logic [BITS-1:0] cnt_q, cnt_d;

   assign at_max_o = (cnt_q == bound_i - 1'b1);
   assign cnt_o    = cnt_q;

   // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)   cnt_d = '0;
      else if (en_i) cnt_d = at_max_o ? '0 : cnt_q + 1'b1;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/loop_sequencer.sv
// Nested-loop iteration generator feeding the apu step stream (di, loop_var,
// change_loop_var); level 0 is innermost, levels chain through wrap carries.
module loop_sequencer
   import apu_pkg::*;
#(
   parameter int BITS         = BITS_DEF,
   parameter int LOG_LOOP_CNT = LOG_LOOP_CNT_DEF
) (
   input logic             clk,
   input logic             reset,
   loop_sequencer_if.slave bus
);

   localparam int LOOP_CNT = 1 << LOG_LOOP_CNT;

   seq_state_e              state_q;
   logic [BITS-1:0]         bound_q [LOOP_CNT];
   logic                    busy_q, done_q, iter_valid_q, change_q, first_q;
   logic [BITS-1:0]         di_q;
   logic [LOG_LOOP_CNT-1:0] loop_var_q;

   logic [BITS-1:0]         cnt    [LOOP_CNT];
   logic [LOOP_CNT-1:0]     at_max, en, inc;
   logic [LOOP_CNT*BITS-1:0] idx_flat;
   logic [LOG_LOOP_CNT-1:0] step_lv;
   logic                    advance, clear, all_max, any_zero;

   assign all_max = &at_max;
   assign advance = (state_q == RUN) && !bus.stall && !all_max;
   assign clear   = (state_q == IDLE) && bus.start;

   // Carry chain: a level steps only when every level below it is wrapping.
   always_comb begin
      en    = '0;
      en[0] = advance;
      for (int k = 1; k < LOOP_CNT; k++) en[k] = en[k-1] & at_max[k-1];
      inc = en & ~at_max;
   end

   always_comb begin
      step_lv = '0;
      for (int k = 0; k < LOOP_CNT; k++)
         if (inc[k]) step_lv = LOG_LOOP_CNT'(k);
   end

   always_comb begin
      any_zero = 1'b0;
      idx_flat = '0;
      for (int k = 0; k < LOOP_CNT; k++) begin
         if (bound_q[k] == '0) any_zero = 1'b1;
         idx_flat[k*BITS +: BITS] = cnt[k];
      end
   end

   for (genvar g = 0; g < LOOP_CNT; g++) begin : g_level
      loop_level #(.BITS(BITS)) u_level (
         .clk      (clk),
         .reset    (reset),
         .clear_i  (clear),
         .en_i     (en[g]),
         .bound_i  (bound_q[g]),
         .cnt_o    (cnt[g]),
         .at_max_o (at_max[g])
      );
   end

   // NOTE: the bound table is a handful of flops, so it is reset like any other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         for (int k = 0; k < LOOP_CNT; k++) bound_q[k] <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         iter_valid_q <= 1'b0;
         di_q         <= '0;
         loop_var_q   <= '0;
         change_q     <= 1'b0;
         first_q      <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         di_q     <= '0;
         change_q <= 1'b0;
         if (bus.cfg_we && state_q != RUN) bound_q[bus.cfg_idx] <= bus.cfg_bound;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (any_zero) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q      <= RUN;
                     busy_q       <= 1'b1;
                     iter_valid_q <= 1'b1;
                     first_q      <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!bus.stall) begin
                  if (all_max) begin
                     state_q      <= DONE;
                     busy_q       <= 1'b0;
                     iter_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                  end else begin
                     di_q       <= BITS'(1);
                     loop_var_q <= step_lv;
                     change_q   <= first_q || (step_lv != loop_var_q);
                     first_q    <= 1'b0;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.iter_valid      = iter_valid_q;
   assign bus.iter_idx        = idx_flat;
   assign bus.di              = di_q;
   assign bus.loop_var        = loop_var_q;
   assign bus.change_loop_var = change_q;

endmodule
